// File: rtl/mem_accum_datapath.sv
// mem_accum_datapath
//   Word-addressed register-file memory feeding a wrapping accumulator with a
//   sticky carry flag. A controller reads words into the accumulator and
//   writes the accumulator back to memory. A host port can preload words
//   whenever the controller is not writing. A controller write to the last
//   address also publishes the written value on 'total'.
//
// Ports
//   clk               clock, all state changes on the rising edge
//   reset             asynchronous active-high reset, clears all state
//   mem_address       controller word address
//   mem_read_enable   load mem[mem_address] into mem_data_out
//   mem_write_enable  store accum_value into mem[mem_address]
//   accum_enable      accum_value += mem_data_out
//   accum_reset       clear accumulator and overflow (wins over accum_enable)
//   host_we           host preload strobe
//   host_addr         host preload address
//   host_wdata        host preload data
//   mem_data_out      registered read data
//   accum_value       accumulator contents
//   overflow          sticky carry-out of the accumulator
//   total             last value written by the controller to the last address
//   total_valid       one-cycle pulse after total is loaded
//   host_drop         one-cycle pulse after a host write lost to the controller
module mem_accum_datapath #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic              mem_read_enable,
  input  logic              mem_write_enable,
  input  logic              accum_enable,
  input  logic              accum_reset,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] accum_value,
  output logic              overflow,
  output logic [DATA_W-1:0] total,
  output logic              total_valid,
  output logic              host_drop
);

  localparam logic [ADDR_W-1:0] TOTAL_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W:0]   sum;
  logic              total_hit;

  assign total_hit = mem_write_enable && (mem_address == TOTAL_ADDR);

  always_comb begin
    sum = '0;
    sum = {1'b0, accum_value} + {1'b0, mem_data_out};
  end

  // Controller write has priority over the host port on the single write path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_write_enable) begin
      mem[mem_address] <= accum_value;
    end else if (host_we) begin
      mem[host_addr] <= host_wdata;
    end
  end

  // Non-blocking read of the array yields the pre-edge word, so a same-cycle
  // write to the same address is seen only by the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_data_out <= '0;
    end else if (mem_read_enable) begin
      mem_data_out <= mem[mem_address];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accum_value <= '0;
      overflow    <= 1'b0;
    end else if (accum_reset) begin
      accum_value <= '0;
      overflow    <= 1'b0;
    end else if (accum_enable) begin
      accum_value <= sum[DATA_W-1:0];
      overflow    <= overflow | sum[DATA_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total       <= '0;
      total_valid <= 1'b0;
      host_drop   <= 1'b0;
    end else begin
      if (total_hit) total <= accum_value;
      total_valid <= total_hit;
      host_drop   <= host_we & mem_write_enable;
    end
  end

endmodule

// File: doc/mem_accum_datapath.md
MEM_ACCUM_DATAPATH -- requirements
Module: mem_accum_datapath

Interface
REQ-001 Parameter DATA_W, 16, width of memory words, accumulator and total.
REQ-002 Parameter DEPTH, 32, number of memory words; address width is 5 bits.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 mem_address  input  5  word address from controller.
REQ-006 mem_read_enable  input  1  controller read request.
REQ-007 mem_write_enable  input  1  controller write request; write data is the accumulator.
REQ-008 accum_enable  input  1  add mem_data_out into accumulator.
REQ-009 accum_reset  input  1  clear accumulator and overflow flag.
REQ-010 host_we  input  1  host preload write strobe.
REQ-011 host_addr  input  5  host preload address.
REQ-012 host_wdata  input  16  host preload data.
REQ-013 mem_data_out  output  16  registered read data to controller.
REQ-014 accum_value  output  16  current accumulator contents.
REQ-015 overflow  output  1  sticky carry-out flag of accumulator.
REQ-016 total  output  16  last value written to address 31.
REQ-017 total_valid  output  1  one-cycle pulse when total updates.
REQ-018 host_drop  output  1  one-cycle pulse when a host write is discarded.

Function
REQ-019 Memory SHALL be a DEPTH x DATA_W register array.
REQ-020 Read latency SHALL be 1 cycle: mem_read_enable high at edge N loads mem[mem_address] into mem_data_out at edge N.
REQ-021 The loaded value SHALL be valid throughout cycle N+1.
REQ-022 mem_data_out SHALL hold its value when mem_read_enable is low.
REQ-023 mem_write_enable high at edge N SHALL write the pre-edge accum_value into mem[mem_address].
REQ-024 Read and write in the same cycle SHALL be read-before-write: mem_data_out gets the old word, even at the same address.
REQ-025 accum_reset high SHALL set accum_value=0 and overflow=0 at the next edge.
REQ-026 accum_reset SHALL take priority over accum_enable.
REQ-027 accum_enable high (accum_reset low) SHALL set accum_value to (accum_value + mem_data_out) mod 2^16.
REQ-028 On that add, overflow SHALL be set if the 17-bit sum bit 16 is 1.
REQ-029 overflow SHALL otherwise hold its value.
REQ-030 Accumulator and overflow SHALL hold when neither accum_reset nor accum_enable is high.
REQ-031 host_we SHALL write host_wdata to mem[host_addr] when mem_write_enable is low.
REQ-032 host_we and mem_write_enable high in the same cycle: the controller write SHALL win, the host write SHALL be discarded, and host_drop SHALL pulse high the following cycle.
REQ-033 A controller write to address 31 SHALL also load total with the written value.
REQ-034 total_valid SHALL be high in the cycle following that edge only.
REQ-035 Host writes to address 31 SHALL NOT update total or pulse total_valid.
REQ-036 Addresses SHALL use all 5 bits; there is no out-of-range case and no wrap logic.
REQ-037 A read of a word written at the previous edge SHALL return the new value.

Reset
REQ-038 Reset SHALL asynchronously clear all memory words, mem_data_out, accum_value, overflow, total, total_valid and host_drop to 0.
REQ-039 While reset is high, all inputs SHALL be ignored.
REQ-040 Reset asserted mid-operation SHALL discard the in-flight read data and accumulator contents.
REQ-041 The first edge after reset deassertion SHALL be processed normally.

Verification
REQ-042 Sequence test: host preloads mem[0..3]=1,2,3,4; then 4x (read addr k, then accum_enable), then write addr 4 -> mem[4]=10, accum_value=10, overflow=0.
REQ-043 Overflow test: accum_value=0xFFF0; read word 0x0020 and add -> accum_value=0x0010, overflow=1; accum_reset -> both 0.
REQ-044 Total test: accum_value=0x1234; write addr 31 -> total=0x1234, total_valid high exactly 1 cycle; host write 0x5555 to addr 31 -> total unchanged, no pulse.
REQ-045 Conflict test: host_we addr 2 data 0xAAAA plus controller write addr 2 with accum=0x0007 in the same cycle -> mem[2]=0x0007, host_drop pulses once.
REQ-046 RAW test: read addr 5 and write addr 5 in the same cycle (old 0x0003, accum 0x0009) -> mem_data_out=0x0003; next read -> 0x0009.
REQ-047 Reset test: assert reset mid-accumulation with accum=0x0042 -> all outputs 0 immediately; subsequent reads of any address return 0.
